// File: rtl/debounce_pulse_pkg.sv
// Shared definitions for the button debounce / press-pulse block.
package debounce_pulse_pkg;

  // Debounce FSM states: two settled levels, each with a qualification state
  // in which a candidate level change is being confirmed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DB_RISE = 2'd1,
    ST_HIGH    = 2'd2,
    ST_DB_FALL = 2'd3
  } db_state_t;

  // Stability window used in simulation; board builds override the parameter.
  localparam int SIM_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_pulse_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; only q is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw push-button and emits a one-cycle T pulse per accepted
// press, plus the debounced level and a wrapping 8-bit press counter.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int STABLE_CYCLES = SIM_STABLE_CYCLES,
  parameter int CNT_WIDTH     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       T,
  output logic       btn_level,
  output logic [7:0] presses
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 btn_sync;
  db_state_t            state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 level_nxt;
  logic                 t_nxt;
  logic                 press_inc;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // Next-state logic: any disagreeing sample during qualification throws
  // the whole window away, so the counter never carries partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    t_nxt     = 1'b0;
    press_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (btn_sync) begin
          state_nxt = ST_DB_RISE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_DB_RISE: begin
        if (!btn_sync) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          t_nxt     = 1'b1;
          press_inc = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        cnt_nxt = '0;
        if (!btn_sync) begin
          state_nxt = ST_DB_FALL;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_DB_FALL: begin
        if (btn_sync) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset discards any press in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      T         <= 1'b0;
      presses   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      T         <= t_nxt;
      if (press_inc) begin
        presses <= presses + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse with a downstream toggle flop.
module tb_debounce_pulse;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b0;
  logic       T;
  logic       btn_level;
  logic [7:0] presses;
  logic       tff_q;

  int errors = 0;
  int checks = 0;

  // Reference model: synchronizer history plus run length of samples
  // that disagree with the settled level.
  logic m_s1, m_s2, m_lvl, m_t;
  int   m_run, m_presses;

  int   edge_no = 0;
  int   pulse_cnt = 0;
  int   last_pulse_edge = -1;
  int   tff_toggles = 0;
  logic dut_t_prev = 1'b0;

  always #5 clk = ~clk;

  debounce_pulse #(.STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .T         (T),
    .btn_level (btn_level),
    .presses   (presses)
  );

  // Downstream toggle flop fed by T.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tff_q <= 1'b0;
    else if (T) tff_q <= ~tff_q;
  end

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_t = 0; m_run = 0; m_presses = 0;
  endtask

  // Drive one input value for one clock edge and advance the model.
  task automatic tick(input logic b);
    logic s;
    logic q_before;
    btn_in     = b;
    q_before   = tff_q;
    dut_t_prev = T;
    @(posedge clk); #1;
    edge_no++;
    m_t = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (s != m_lvl) begin
        m_run++;
        // Entry sample plus S qualifying samples accept the change.
        if (m_run == S + 1) begin
          m_lvl = s;
          m_run = 0;
          if (s) begin
            m_t = 1'b1;
            m_presses = (m_presses + 1) % 256;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    if (T === 1'b1) begin
      pulse_cnt++;
      last_pulse_edge = edge_no;
    end
    if (tff_q !== q_before) tff_toggles++;
  endtask

  task automatic test_reset();
    int base;
    btn_in = 1'b1;
    rst_n  = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      checks++;
      if ({T, btn_level, presses} !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got T=%b lvl=%b presses=%0d, want all 0", edge_no, T, btn_level, presses);
      end
    end
    rst_n = 1'b1;
    base = edge_no;
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      checks++;
      if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)}) begin
        errors++;
        $display("FAIL reset_release edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
      end
    end
    checks++;
    if (pulse_cnt !== 1 || (last_pulse_edge - base - 1) !== S + 2) begin
      errors++;
      $display("FAIL reset_release_pulse: got %0d pulses at rel edge %0d, want 1 at %0d", pulse_cnt, last_pulse_edge - base - 1, S + 2);
    end
    checks++;
    if (presses !== 8'd1) begin
      errors++;
      $display("FAIL reset_release_presses: got %0d, want 1", presses);
    end
    for (int i = 0; i < 2 * S + 4; i++) tick(1'b0);
  endtask

  task automatic test_clean_press();
    int base, p0;
    base = edge_no; p0 = presses; pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      checks++;
      if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)}) begin
        errors++;
        $display("FAIL clean_press edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
      end
    end
    checks++;
    if (pulse_cnt !== 1 || (last_pulse_edge - base - 1) !== 6 || btn_level !== 1'b1 || presses !== 8'(p0 + 1)) begin
      errors++;
      $display("FAIL clean_press_summary: got %0d pulses at rel edge %0d lvl=%b presses=%0d, want 1 at 6 lvl=1 presses=%0d", pulse_cnt, last_pulse_edge - base - 1, btn_level, presses, p0 + 1);
    end
  endtask

  task automatic test_glitch_release();
    int base, p0, fall_rel;
    // Release of a held press: level falls, no pulse, count unchanged.
    base = edge_no; p0 = presses; pulse_cnt = 0; fall_rel = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0);
      if (btn_level === 1'b0 && fall_rel < 0) fall_rel = edge_no - base - 1;
      checks++;
      if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)}) begin
        errors++;
        $display("FAIL release edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
      end
    end
    checks++;
    if (fall_rel !== 6 || pulse_cnt !== 0 || presses !== 8'(p0)) begin
      errors++;
      $display("FAIL release_summary: got fall at %0d pulses=%0d presses=%0d, want fall at 6 pulses=0 presses=%0d", fall_rel, pulse_cnt, presses, p0);
    end
    // Short glitch: three cycles high must be ignored.
    pulse_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick(i < 3 ? 1'b1 : 1'b0);
      checks++;
      if (T !== 1'b0 || btn_level !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge %0d: got T=%b lvl=%b, want T=0 lvl=0", edge_no, T, btn_level);
      end
    end
  endtask

  task automatic test_bouncy_press();
    int base, p0;
    logic pat [$];
    pat = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) pat.push_back(1'b1);
    base = edge_no; p0 = presses; pulse_cnt = 0;
    foreach (pat[i]) begin
      tick(pat[i]);
      checks++;
      if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)}) begin
        errors++;
        $display("FAIL bouncy edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
      end
    end
    checks++;
    if (pulse_cnt !== 1 || (last_pulse_edge - base - 1) !== 7 + 6 || presses !== 8'(p0 + 1)) begin
      errors++;
      $display("FAIL bouncy_summary: got %0d pulses at rel edge %0d presses=%0d, want 1 at 13 presses=%0d", pulse_cnt, last_pulse_edge - base - 1, presses, p0 + 1);
    end
  endtask

  task automatic test_reset_midqual();
    for (int i = 0; i < 4; i++) tick(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({T, btn_level, presses} !== 10'd0) begin
      errors++;
      $display("FAIL reset_async: got T=%b lvl=%b presses=%0d, want all 0", T, btn_level, presses);
    end
    for (int i = 0; i < 3; i++) tick(1'b0);
    rst_n = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0);
      checks++;
      if ({T, btn_level, presses} !== 10'd0) begin
        errors++;
        $display("FAIL reset_midqual edge %0d: got T=%b lvl=%b presses=%0d, want all 0", edge_no, T, btn_level, presses);
      end
    end
  endtask

  task automatic test_wrap_tff();
    logic q0;
    q0 = tff_q; pulse_cnt = 0; tff_toggles = 0;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 40; i++) begin
        tick(i < 20 ? 1'b1 : 1'b0);
        checks++;
        if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)} || (T === 1'b1 && dut_t_prev === 1'b1)) begin
          errors++;
          $display("FAIL wrap edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
        end
      end
    end
    checks++;
    if (pulse_cnt !== 256 || presses !== 8'd0 || tff_toggles !== 256 || tff_q !== q0) begin
      errors++;
      $display("FAIL wrap_summary: got pulses=%0d presses=%0d toggles=%0d q=%b, want 256 0 256 q=%b", pulse_cnt, presses, tff_toggles, tff_q, q0);
    end
  endtask

  task automatic test_random();
    int exp_pulses, len;
    logic lvl;
    pulse_cnt = 0; exp_pulses = 0; lvl = 1'b0;
    for (int r = 0; r < 120; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        tick(lvl);
        if (m_t) exp_pulses++;
        checks++;
        if ({T, btn_level, presses} !== {m_t, m_lvl, 8'(m_presses)} || (T === 1'b1 && dut_t_prev === 1'b1)) begin
          errors++;
          $display("FAIL random edge %0d: got T=%b lvl=%b presses=%0d, want T=%b lvl=%b presses=%0d", edge_no, T, btn_level, presses, m_t, m_lvl, m_presses);
        end
      end
    end
    checks++;
    if (pulse_cnt !== exp_pulses) begin
      errors++;
      $display("FAIL random_pulses: got %0d, want %0d", pulse_cnt, exp_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch_release();
    test_bouncy_press();
    for (int i = 0; i < 12; i++) tick(1'b0);
    test_reset_midqual();
    test_wrap_tff();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
